// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive-side controller.
// Holds the character and divisor widths, the default FIFO/timeout/divisor
// settings, and the character-timeout FSM state type.
package uart_rx_ctrl_pkg;

    localparam int UART_DATA_SIZE       = 8;
    localparam int UART_BAUD_DIV_SIZE   = 16;
    localparam int UART_RX_FIFO_DEPTH   = 8;
    localparam int UART_BAUD_DIV_RST    = 868;
    localparam int UART_RX_TIMEOUT_BITS = 40;

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_COUNT,
        TO_EXPIRED
    } type_uart_rx_to_states_e;

    // Width of an occupancy count: one bit wider than the pointers so that a
    // full FIFO is distinguishable from an empty one.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Read port of the RX FIFO: valid/ready handshake, head data and occupancy.
// master: the controller (drives rd_valid_o, rd_data_o, level_o).
// slave : the consumer (drives rd_ready_i).
interface uart_rx_ctrl_if
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_RX_FIFO_DEPTH
) ();

    logic                               rd_valid_o;
    logic                               rd_ready_i;
    logic [UART_DATA_SIZE-1:0]          rd_data_o;
    logic [level_width(FIFO_DEPTH)-1:0] level_o;

    modport master (
        output rd_valid_o,
        output rd_data_o,
        output level_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o,
        input  rd_data_o,
        input  level_o,
        output rd_ready_i
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data (dropped when full unless a
//                       pop is accepted in the same cycle)
//   pop               : read request (ignored when empty)
//   push_done/pop_done: the request was accepted this cycle
//   head              : oldest entry, valid one cycle after it is written
//   level, full, empty: occupancy status
// Reusable on the TX side.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic                      push_done,
    output logic                      pop_done,
    output logic [WIDTH-1:0]          head,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      level_reg;
    logic [WIDTH-1:0] head_reg;

    assign empty       = (level_reg == '0);
    assign full        = (level_reg == LVL_FULL);
    assign pop_done    = pop && !empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push_done   = push && (!full || pop_done);
    assign rd_ptr_next = rd_ptr_reg + 1'b1;

    assign head  = head_reg;
    assign level = level_reg;

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_done) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_done) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_done) begin
                rd_ptr_reg <= rd_ptr_next;
            end

            case ({push_done, pop_done})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase

            // Head register: the next entry is either already in the array
            // or is the character being written right now (FIFO about to be
            // empty / already empty). With two or more entries the slot at
            // rd_ptr_next is never the one being written this cycle.
            if (pop_done) begin
                if (level_reg == LVL_ONE) begin
                    if (push_done) begin
                        head_reg <= push_data;
                    end
                end else begin
                    head_reg <= mem[rd_ptr_next];
                end
            end else if (empty && push_done) begin
                head_reg <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: owns the receiver's baud divisor and enable,
// buffers received characters in a FIFO with a valid/ready read port, keeps
// sticky overrun/frame-error flags, runs the character-timeout FSM and forms
// the combined interrupt.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rx_data_i/valid/frame_err  : character and status pulses from uart_rx
//   baud_div_o                 : divisor to uart_rx
//   cfg_*                      : configuration write (all fields load together)
//   clr_err_i                  : clears both sticky error flags
//   overrun_o, frame_err_o     : sticky error flags
//   timeout_o                  : character-timeout flag
//   irq_o                      : combined interrupt
//   rd_if                      : FIFO read port (valid/ready, data, level)
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = UART_RX_FIFO_DEPTH,
    parameter int TIMEOUT_BITS = UART_RX_TIMEOUT_BITS,
    parameter int BAUD_DIV_RST = UART_BAUD_DIV_RST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [UART_DATA_SIZE-1:0]     rx_data_i,
    input  logic                          rx_valid_i,
    input  logic                          rx_frame_err_i,
    output logic [UART_BAUD_DIV_SIZE-1:0] baud_div_o,
    input  logic                          cfg_we_i,
    input  logic [UART_BAUD_DIV_SIZE-1:0] cfg_baud_div_i,
    input  logic                          cfg_rx_en_i,
    input  logic [$clog2(FIFO_DEPTH):0]   cfg_thresh_i,
    input  logic                          cfg_err_ie_i,
    input  logic                          clr_err_i,
    output logic                          overrun_o,
    output logic                          frame_err_o,
    output logic                          timeout_o,
    output logic                          irq_o,
    uart_rx_ctrl_if.master                rd_if
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [LW-1:0]                 LVL_ONE  = LW'(1);
    localparam logic [CW-1:0]                 BITS_END = CW'(TIMEOUT_BITS);
    localparam logic [UART_BAUD_DIV_SIZE-1:0] DIV_ONE  = UART_BAUD_DIV_SIZE'(1);

    // Configuration registers
    logic [UART_BAUD_DIV_SIZE-1:0] baud_div_reg;
    logic                          rx_en_reg;
    logic [LW-1:0]                 thresh_reg;
    logic                          err_ie_reg;

    // FIFO status
    logic                      push_req;
    logic                      push_done;
    logic                      pop_done;
    logic [UART_DATA_SIZE-1:0] fifo_head;
    logic [LW-1:0]             fifo_level;
    logic                      fifo_full;
    logic                      fifo_empty;

    // Flags and timeout FSM
    logic                          overrun_reg;
    logic                          frame_err_reg;
    logic                          overrun_set;
    logic                          frame_err_set;
    type_uart_rx_to_states_e       to_state_reg;
    logic [UART_BAUD_DIV_SIZE-1:0] prescale_reg;
    logic [CW-1:0]                 bit_cnt_reg;
    logic [CW-1:0]                 bit_cnt_inc;
    logic                          timeout_reg;
    logic                          activity;
    logic                          will_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_reg <= UART_BAUD_DIV_SIZE'(BAUD_DIV_RST);
            rx_en_reg    <= 1'b1;
            thresh_reg   <= LVL_ONE;
            err_ie_reg   <= 1'b0;
        end else if (cfg_we_i) begin
            baud_div_reg <= cfg_baud_div_i;
            rx_en_reg    <= cfg_rx_en_i;
            thresh_reg   <= cfg_thresh_i;
            err_ie_reg   <= cfg_err_ie_i;
        end
    end

    assign baud_div_o = baud_div_reg;

    // A character flagged with a bad stop bit is never stored.
    assign push_req = rx_valid_i && !rx_frame_err_i && rx_en_reg;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx_data_i),
        .pop       (rd_if.rd_ready_i),
        .push_done (push_done),
        .pop_done  (pop_done),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_if.rd_valid_o = !fifo_empty;
    assign rd_if.rd_data_o  = fifo_head;
    assign rd_if.level_o    = fifo_level;

    // Sticky error flags; a set in the same cycle as a clear wins.
    assign overrun_set   = push_req && fifo_full && !pop_done;
    assign frame_err_set = rx_frame_err_i && rx_en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overrun_reg   <= overrun_set   | (overrun_reg   & ~clr_err_i);
            frame_err_reg <= frame_err_set | (frame_err_reg & ~clr_err_i);
        end
    end

    assign overrun_o   = overrun_reg;
    assign frame_err_o = frame_err_reg;

    // Character timeout. The count restarts on every accepted push or pop;
    // the last pop out of the FIFO sends the FSM back to idle.
    assign activity    = push_done || pop_done;
    assign will_empty  = pop_done && !push_done && (fifo_level == LVL_ONE);
    assign bit_cnt_inc = bit_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_state_reg <= TO_IDLE;
            prescale_reg <= '0;
            bit_cnt_reg  <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            case (to_state_reg)
                TO_IDLE: begin
                    timeout_reg <= 1'b0;
                    // Start counting as the first character lands, so expiry is
                    // measured from the FIFO becoming non-empty.
                    if ((push_done || !fifo_empty) && !will_empty) begin
                        to_state_reg <= TO_COUNT;
                        prescale_reg <= baud_div_reg;
                        bit_cnt_reg  <= '0;
                    end
                end
                TO_COUNT, TO_EXPIRED: begin
                    if (will_empty || (fifo_empty && !push_done)) begin
                        to_state_reg <= TO_IDLE;
                        timeout_reg  <= 1'b0;
                    end else if (activity) begin
                        to_state_reg <= TO_COUNT;
                        prescale_reg <= baud_div_reg;
                        bit_cnt_reg  <= '0;
                        timeout_reg  <= 1'b0;
                    end else if (to_state_reg == TO_COUNT) begin
                        // Divisor 0 is treated like 1 so the counter cannot stall.
                        if (prescale_reg <= DIV_ONE) begin
                            prescale_reg <= baud_div_reg;
                            bit_cnt_reg  <= bit_cnt_inc;
                            if (bit_cnt_inc == BITS_END) begin
                                to_state_reg <= TO_EXPIRED;
                                timeout_reg  <= 1'b1;
                            end
                        end else begin
                            prescale_reg <= prescale_reg - DIV_ONE;
                        end
                    end
                end
                default: begin
                    to_state_reg <= TO_IDLE;
                    timeout_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_o = timeout_reg;

    assign irq_o = ((thresh_reg != '0) && (fifo_level >= thresh_reg))
                 | timeout_reg
                 | (err_ie_reg & (overrun_reg | frame_err_reg));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                          clk;
    logic                          rst_n;
    logic [UART_DATA_SIZE-1:0]     rx_data_i;
    logic                          rx_valid_i;
    logic                          rx_frame_err_i;
    logic [UART_BAUD_DIV_SIZE-1:0] baud_div_o;
    logic                          cfg_we_i;
    logic [UART_BAUD_DIV_SIZE-1:0] cfg_baud_div_i;
    logic                          cfg_rx_en_i;
    logic [LW-1:0]                 cfg_thresh_i;
    logic                          cfg_err_ie_i;
    logic                          clr_err_i;
    logic                          overrun_o;
    logic                          frame_err_o;
    logic                          timeout_o;
    logic                          irq_o;

    uart_rx_ctrl_if #(.FIFO_DEPTH(DEPTH)) rd_if ();

    uart_rx_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .TIMEOUT_BITS (40),
        .BAUD_DIV_RST (868)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .baud_div_o     (baud_div_o),
        .cfg_we_i       (cfg_we_i),
        .cfg_baud_div_i (cfg_baud_div_i),
        .cfg_rx_en_i    (cfg_rx_en_i),
        .cfg_thresh_i   (cfg_thresh_i),
        .cfg_err_ie_i   (cfg_err_ie_i),
        .clr_err_i      (clr_err_i),
        .overrun_o      (overrun_o),
        .frame_err_o    (frame_err_o),
        .timeout_o      (timeout_o),
        .irq_o          (irq_o),
        .rd_if          (rd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];   // scoreboard: characters the FIFO must return
    logic       en_m = 1'b1; // model of the receive enable

    // All tasks start and end on a falling edge.
    task automatic cfg_write(input logic [15:0] div, input logic en,
                             input logic [LW-1:0] th, input logic ie);
        cfg_baud_div_i = div;
        cfg_rx_en_i    = en;
        cfg_thresh_i   = th;
        cfg_err_ie_i   = ie;
        cfg_we_i       = 1'b1;
        @(negedge clk);
        cfg_we_i = 1'b0;
        en_m     = en;
        $display("cfg  div=%0d en=%0b thresh=%0d err_ie=%0b", div, en, th, ie);
    endtask

    task automatic push_char(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        if (en_m && exp_q.size() < DEPTH) exp_q.push_back(b);
        @(negedge clk);
        rx_valid_i = 1'b0;
        $display("push 0x%02h level=%0d", b, rd_if.level_o);
    endtask

    task automatic pop_one();
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_empty_model: got rd_valid=%0b data=0x%02h, scoreboard empty",
                     rd_if.rd_valid_o, rd_if.rd_data_o);
        end else begin
            exp = exp_q.pop_front();
            if (rd_if.rd_valid_o !== 1'b1 || rd_if.rd_data_o !== exp) begin
                errors++;
                $display("FAIL pop_data: got valid=%0b data=0x%02h expected valid=1 data=0x%02h",
                         rd_if.rd_valid_o, rd_if.rd_data_o, exp);
            end
        end
        rd_if.rd_ready_i = 1'b1;
        @(negedge clk);
        rd_if.rd_ready_i = 1'b0;
        $display("pop  level=%0d", rd_if.level_o);
    endtask

    task automatic test_reset();
        checks++;
        if (rd_if.rd_valid_o !== 1'b0 || rd_if.rd_data_o !== 8'h00 || rd_if.level_o !== '0 ||
            overrun_o !== 1'b0 || frame_err_o !== 1'b0 || timeout_o !== 1'b0 ||
            irq_o !== 1'b0 || baud_div_o !== 16'd868) begin
            errors++;
            $display("FAIL reset_values: got v=%0b d=%02h l=%0d ov=%0b fe=%0b to=%0b irq=%0b div=%0d expected 0 0 0 0 0 0 0 868",
                     rd_if.rd_valid_o, rd_if.rd_data_o, rd_if.level_o, overrun_o, frame_err_o,
                     timeout_o, irq_o, baud_div_o);
        end
    endtask

    task automatic test_basic();
        push_char(8'h41);
        push_char(8'h42);
        push_char(8'h43);
        checks++;
        if (rd_if.level_o !== LW'(3)) begin
            errors++;
            $display("FAIL basic_level: got %0d expected 3", rd_if.level_o);
        end
        for (int i = 0; i < 3; i++) pop_one();
        checks++;
        if (rd_if.rd_valid_o !== 1'b0 || rd_if.level_o !== '0) begin
            errors++;
            $display("FAIL basic_drained: got valid=%0b level=%0d expected 0 0",
                     rd_if.rd_valid_o, rd_if.level_o);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) push_char(8'h10 + 8'(i));
        checks++;
        if (rd_if.level_o !== LW'(DEPTH) || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL full_level: got level=%0d ov=%0b expected 8 0", rd_if.level_o, overrun_o);
        end
        push_char(8'h99);
        checks++;
        if (overrun_o !== 1'b1 || rd_if.level_o !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL overrun_set: got ov=%0b level=%0d expected 1 8", overrun_o, rd_if.level_o);
        end
        // Push and pop together while full.
        checks++;
        if (rd_if.rd_data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL full_head: got 0x%02h expected 0x%02h", rd_if.rd_data_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA5);
        rx_data_i        = 8'hA5;
        rx_valid_i       = 1'b1;
        rd_if.rd_ready_i = 1'b1;
        @(negedge clk);
        rx_valid_i       = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        $display("push+pop 0xa5 level=%0d", rd_if.level_o);
        checks++;
        if (rd_if.level_o !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_pushpop_level: got %0d expected 8", rd_if.level_o);
        end
        for (int i = 0; i < DEPTH; i++) pop_one();
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %0b expected 0", overrun_o);
        end
    endtask

    task automatic test_frame_err();
        cfg_write(16'd868, 1'b1, LW'(1), 1'b1);
        rx_data_i      = 8'h77;
        rx_valid_i     = 1'b1;
        rx_frame_err_i = 1'b1;
        @(negedge clk);
        rx_valid_i     = 1'b0;
        rx_frame_err_i = 1'b0;
        $display("frame error with data 0x77");
        checks++;
        if (frame_err_o !== 1'b1 || irq_o !== 1'b1 || rd_if.level_o !== '0) begin
            errors++;
            $display("FAIL frame_err_set: got fe=%0b irq=%0b level=%0d expected 1 1 0",
                     frame_err_o, irq_o, rd_if.level_o);
        end
        rx_frame_err_i = 1'b1;
        clr_err_i      = 1'b1;
        @(negedge clk);
        rx_frame_err_i = 1'b0;
        clr_err_i      = 1'b0;
        checks++;
        if (frame_err_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_set_wins: got %0b expected 1", frame_err_o);
        end
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        checks++;
        if (frame_err_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: got fe=%0b irq=%0b expected 0 0", frame_err_o, irq_o);
        end
    endtask

    task automatic test_timeout();
        int k;
        cfg_write(16'd4, 1'b1, LW'(0), 1'b0);
        push_char(8'h5A);
        k = 0;
        while (timeout_o !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        $display("timeout after %0d cycles", k);
        checks++;
        if (k < 159 || k > 161) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles expected 160 +-1", k);
        end
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_irq: got %0b expected 1", irq_o);
        end
        pop_one();
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %0b expected 0", timeout_o);
        end
    endtask

    task automatic test_thresh_enable();
        cfg_write(16'd868, 1'b1, LW'(4), 1'b0);
        push_char(8'h01);
        push_char(8'h02);
        push_char(8'h03);
        checks++;
        if (irq_o !== 1'b0 || rd_if.level_o !== LW'(3)) begin
            errors++;
            $display("FAIL thresh_below: got irq=%0b level=%0d expected 0 3", irq_o, rd_if.level_o);
        end
        push_char(8'h04);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL thresh_reached: got irq=%0b expected 1", irq_o);
        end
        cfg_write(16'd868, 1'b0, LW'(4), 1'b0);
        push_char(8'hEE);
        checks++;
        if (rd_if.level_o !== LW'(4)) begin
            errors++;
            $display("FAIL disabled_push: got level=%0d expected 4", rd_if.level_o);
        end
        for (int i = 0; i < 4; i++) pop_one();
        checks++;
        if (rd_if.rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disabled_drain: got valid=%0b expected 0", rd_if.rd_valid_o);
        end
        cfg_write(16'd868, 1'b1, LW'(1), 1'b0);
    endtask

    task automatic test_baud_reset();
        cfg_write(16'd27, 1'b1, LW'(1), 1'b1);
        checks++;
        if (baud_div_o !== 16'd27) begin
            errors++;
            $display("FAIL baud_write: got %0d expected 27", baud_div_o);
        end
        push_char(8'hC1);
        push_char(8'hC2);
        rx_frame_err_i = 1'b1;
        @(negedge clk);
        rx_frame_err_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        $display("async reset mid-fill");
        checks++;
        if (rd_if.rd_valid_o !== 1'b0 || rd_if.rd_data_o !== 8'h00 || rd_if.level_o !== '0 ||
            overrun_o !== 1'b0 || frame_err_o !== 1'b0 || timeout_o !== 1'b0 ||
            irq_o !== 1'b0 || baud_div_o !== 16'd868) begin
            errors++;
            $display("FAIL midreset_values: got v=%0b d=%02h l=%0d ov=%0b fe=%0b to=%0b irq=%0b div=%0d expected 0 0 0 0 0 0 0 868",
                     rd_if.rd_valid_o, rd_if.rd_data_o, rd_if.level_o, overrun_o, frame_err_o,
                     timeout_o, irq_o, baud_div_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en_m  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n            = 1'b0;
        rx_data_i        = '0;
        rx_valid_i       = 1'b0;
        rx_frame_err_i   = 1'b0;
        cfg_we_i         = 1'b0;
        cfg_baud_div_i   = '0;
        cfg_rx_en_i      = 1'b0;
        cfg_thresh_i     = '0;
        cfg_err_ie_i     = 1'b0;
        clr_err_i        = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_timeout();
        test_thresh_enable();
        test_baud_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
